clock_set_ctrl: RTL and testbench
=================================

Name: clock_set_ctrl

Overview:
- Timekeeping and time-set controller for the binary wall clock.
- Owns the HH:MM BCD digit registers and an internal seconds count, divides hwclk down to a 1 Hz advance enable, and sequences a RUN / SET_HOURS / SET_MINUTES mode FSM from two raw push-buttons.
- Outputs feed the LED drivers directly; blank flags let the display flash the field being set.

Parameters:
- TICK_DIV, 12000000, hwclk cycles per second tick (12 MHz board clock).
- DEBOUNCE, 120000, consecutive stable cycles before a button level is accepted (10 ms).
- BLINK_DIV, 3000000, hwclk cycles per blink phase in set modes (0.25 s).

Ports:
- hwclk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- btn_mode  in  1  raw mode button, active-high, asynchronous to hwclk
- btn_inc  in  1  raw increment button, active-high, asynchronous to hwclk
- dm0  out  4  minutes units BCD, 0..9
- dm1  out  4  minutes tens BCD, 0..5
- dh0  out  4  hours units BCD, 0..9
- dh1  out  4  hours tens BCD, 0..2
- mode  out  2  0=RUN, 1=SET_HOURS, 2=SET_MINUTES; 3 is never produced
- blank_h  out  1  hour digits to be blanked this cycle
- blank_m  out  1  minute digits to be blanked this cycle
- sec_tick  out  1  one-cycle pulse per second tick in RUN

Behaviour:
- Reset (sync, rst=1 at the clock edge):
  - all digits 0; seconds 0; mode RUN.
  - blank_h=0, blank_m=0, sec_tick=0.
  - prescaler, blink counter and debounce counters 0; debounced levels 0.
  - Reset applies mid-operation in any mode, same result.
- Button conditioning (each button independently):
  - 2-FF synchronizer.
  - Counter clears whenever the synced value equals the debounced level; otherwise it increments.
  - When the count reaches DEBOUNCE-1, the debounced level takes the synced value.
  - Press event = one-cycle pulse on a 0->1 debounced transition.
  - Glitches shorter than DEBOUNCE cycles produce no event.
  - A button held through reset release produces one event once it has been stable.
  - Event-to-effect latency is at most DEBOUNCE+4 cycles from the raw edge.
- Prescaler:
  - Counts 0..TICK_DIV-1 in RUN only; held at 0 in set modes.
  - On wrap, sec_tick=1 for exactly one cycle.
- RUN:
  - Each tick advances seconds 0..59.
  - seconds 59 -> 0 with a minute carry.
  - dm0 9 -> 0 carries to dm1; dm1 5 -> 0 carries to hours.
  - Hours count 00..23; 23:59:59 + tick -> 00:00:00.
  - Digit outputs are registered and update on the edge after the sec_tick cycle.
- Mode FSM (mode press):
  - RUN -> SET_HOURS -> SET_MINUTES -> RUN.
  - On leaving SET_MINUTES, seconds and prescaler clear to 0, so the first RUN tick lands a full second later.
- SET_HOURS:
  - Each inc press adds 1 to the hour (BCD pair), 23 -> 00.
  - Minutes and seconds are unchanged; there is no carry.
- SET_MINUTES:
  - Each inc press adds 1 to the minute (BCD pair), 59 -> 00, with no carry into hours.
  - Each press also clears seconds to 0.
- Blink:
  - In set modes, the blink counter wraps every BLINK_DIV cycles and toggles the phase.
  - blank_h = phase in SET_HOURS; blank_m = phase in SET_MINUTES.
  - Both blank flags are 0 in RUN.
  - Entering a set mode, or any inc press, resets counter and phase to 0 so the field is visible immediately.
- Simultaneous events:
  - mode and inc events in the same cycle: mode wins, inc is discarded.
  - A tick coinciding with a mode press out of RUN is applied first, then the mode changes.
  - inc presses in RUN are ignored.
- Invariant: digit outputs never hold a non-BCD or out-of-range value (e.g. dh1=2 with dh0>3 is illegal).

Test Plan (TICK_DIV=4, DEBOUNCE=3, BLINK_DIV=5):
- Reset, run 240 cycles -> 60 sec_tick pulses, dm0=1, other digits 0. Run 14400 cycles total -> dh0=1, dm1=0, dm0=0.
- Rollover to midnight:
  - Stimulus: set 23:59 via SET_HOURS (23 inc) and SET_MINUTES (59 inc), return to RUN, run 60 ticks.
  - Response: digits go 2,3,5,9 -> 0,0,0,0; mode=0.
- Wrap without carry:
  - SET_HOURS, 25 inc presses from 00 -> dh1=0, dh0=1; minutes untouched.
  - SET_MINUTES from 59, 1 inc -> 00, hours unchanged, no sec_tick while in set mode.
- Debounce and priority:
  - 2-cycle pulses on btn_inc -> no change.
  - btn_mode and btn_inc rising on the same cycle in SET_HOURS -> mode=2, hour unchanged.
- Blink:
  - In SET_MINUTES, blank_m toggles every 5 cycles and blank_h stays 0.
  - An inc press forces blank_m=0 on the next cycle.
  - Back in RUN -> both blank flags 0.
- Reset mid-set: rst asserted in SET_MINUTES at 14:37 -> next cycle 00:00, mode=0, blanks 0, sec_tick 0.

Source files
------------

// File: rtl/clock_set_ctrl.sv
// Timekeeping and time-set controller for the binary wall clock: BCD HH:MM registers,
// 1 Hz prescaler, debounced mode/inc buttons and a RUN / SET_HOURS / SET_MINUTES FSM.
module clock_set_ctrl #(
    parameter int TICK_DIV  = 12000000,
    parameter int DEBOUNCE  = 120000,
    parameter int BLINK_DIV = 3000000
) (
    input  logic       hwclk,
    input  logic       rst,
    input  logic       btn_mode,
    input  logic       btn_inc,
    output logic [3:0] dm0,
    output logic [3:0] dm1,
    output logic [3:0] dh0,
    output logic [3:0] dh1,
    output logic [1:0] mode,
    output logic       blank_h,
    output logic       blank_m,
    output logic       sec_tick
);

    localparam int PW = (TICK_DIV  > 1) ? $clog2(TICK_DIV)  : 1;
    localparam int DW = (DEBOUNCE  > 1) ? $clog2(DEBOUNCE)  : 1;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [1:0] S_RUN     = 2'd0;
    localparam logic [1:0] S_HOURS   = 2'd1;
    localparam logic [1:0] S_MINUTES = 2'd2;

    logic [1:0] w_raw;
    logic [1:0] w_press;

    assign w_raw = {btn_inc, btn_mode};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_btn
            logic          r_sync1;
            logic          r_sync2;
            logic          r_level;
            logic          r_level_d;
            logic [DW-1:0] r_cnt;

            always_ff @(posedge hwclk) begin
                if (rst) begin
                    r_sync1   <= 1'b0;
                    r_sync2   <= 1'b0;
                    r_level   <= 1'b0;
                    r_level_d <= 1'b0;
                    r_cnt     <= '0;
                end else begin
                    r_sync1   <= w_raw[gi];
                    r_sync2   <= r_sync1;
                    r_level_d <= r_level;
                    if (r_sync2 == r_level) begin
                        r_cnt <= '0;
                    end else if (r_cnt == DW'(DEBOUNCE - 1)) begin
                        r_level <= r_sync2;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
            end

            assign w_press[gi] = r_level & ~r_level_d;
        end
    endgenerate

    logic [PW-1:0] r_presc;
    logic [BW-1:0] r_blink_cnt;
    logic          r_phase;
    logic [5:0]    r_sec;
    logic [3:0]    r_dm0, r_dm1, r_dh0, r_dh1;
    logic [1:0]    r_mode;
    logic          r_sec_tick;

    logic       w_mode_ev;
    logic       w_inc_ev;
    logic       w_wrap;
    logic [7:0] w_hour_next;
    logic [7:0] w_min_next;

    // A mode press swallows a simultaneous inc press.
    assign w_mode_ev = w_press[0];
    assign w_inc_ev  = w_press[1] & ~w_press[0];
    assign w_wrap    = (r_presc == PW'(TICK_DIV - 1));

    function automatic logic [7:0] hour_inc(input logic [3:0] t, input logic [3:0] u);
        if (t == 4'd2 && u == 4'd3) return 8'h00;
        else if (u == 4'd9)         return {t + 4'd1, 4'd0};
        else                        return {t, u + 4'd1};
    endfunction

    function automatic logic [7:0] min_inc(input logic [3:0] t, input logic [3:0] u);
        if (u != 4'd9)      return {t, u + 4'd1};
        else if (t == 4'd5) return 8'h00;
        else                return {t + 4'd1, 4'd0};
    endfunction

    assign w_hour_next = hour_inc(r_dh1, r_dh0);
    assign w_min_next  = min_inc(r_dm1, r_dm0);

    always_ff @(posedge hwclk) begin
        if (rst) begin
            r_presc     <= '0;
            r_blink_cnt <= '0;
            r_phase     <= 1'b0;
            r_sec       <= 6'd0;
            r_dm0       <= 4'd0;
            r_dm1       <= 4'd0;
            r_dh0       <= 4'd0;
            r_dh1       <= 4'd0;
            r_mode      <= S_RUN;
            r_sec_tick  <= 1'b0;
        end else begin
            r_sec_tick <= 1'b0;

            // No tick is issued on the cycle RUN is left, so sec_tick never shows in a set mode.
            if (r_mode == S_RUN && !w_mode_ev) begin
                if (w_wrap) begin
                    r_presc    <= '0;
                    r_sec_tick <= 1'b1;
                end else begin
                    r_presc <= r_presc + 1'b1;
                end
            end else begin
                r_presc <= '0;
            end

            if (r_sec_tick) begin
                if (r_sec == 6'd59) begin
                    r_sec <= 6'd0;
                    {r_dm1, r_dm0} <= w_min_next;
                    if (r_dm1 == 4'd5 && r_dm0 == 4'd9)
                        {r_dh1, r_dh0} <= w_hour_next;
                end else begin
                    r_sec <= r_sec + 6'd1;
                end
            end

            if (w_mode_ev) begin
                case (r_mode)
                    S_RUN:     r_mode <= S_HOURS;
                    S_HOURS:   r_mode <= S_MINUTES;
                    S_MINUTES: begin
                        r_mode <= S_RUN;
                        r_sec  <= 6'd0;
                    end
                    default:   r_mode <= S_RUN;
                endcase
            end else if (w_inc_ev) begin
                if (r_mode == S_HOURS) begin
                    {r_dh1, r_dh0} <= w_hour_next;
                end else if (r_mode == S_MINUTES) begin
                    {r_dm1, r_dm0} <= w_min_next;
                    r_sec <= 6'd0;
                end
            end

            // Restart blinking visible whenever the edited field changes or is entered.
            if (w_mode_ev || (w_inc_ev && r_mode != S_RUN) || r_mode == S_RUN) begin
                r_blink_cnt <= '0;
                r_phase     <= 1'b0;
            end else if (r_blink_cnt == BW'(BLINK_DIV - 1)) begin
                r_blink_cnt <= '0;
                r_phase     <= ~r_phase;
            end else begin
                r_blink_cnt <= r_blink_cnt + 1'b1;
            end
        end
    end

    assign dm0      = r_dm0;
    assign dm1      = r_dm1;
    assign dh0      = r_dh0;
    assign dh1      = r_dh1;
    assign mode     = r_mode;
    assign sec_tick = r_sec_tick;
    assign blank_h  = r_phase & (r_mode == S_HOURS);
    assign blank_m  = r_phase & (r_mode == S_MINUTES);

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed bench for clock_set_ctrl with shrunk dividers (tick 4, debounce 3, blink 5).
module tb_clock_set_ctrl;

    logic       hwclk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_mode = 1'b0;
    logic       btn_inc = 1'b0;
    logic [3:0] dm0, dm1, dh0, dh1;
    logic [1:0] mode;
    logic       blank_h, blank_m, sec_tick;

    int vectors = 0;
    int miscompares = 0;
    int tick_cnt = 0;
    int bad_ticks = 0;
    int base;
    int n;
    logic [3:0] old_dm0;

    clock_set_ctrl #(.TICK_DIV(4), .DEBOUNCE(3), .BLINK_DIV(5)) dut (
        .hwclk(hwclk), .rst(rst), .btn_mode(btn_mode), .btn_inc(btn_inc),
        .dm0(dm0), .dm1(dm1), .dh0(dh0), .dh1(dh1), .mode(mode),
        .blank_h(blank_h), .blank_m(blank_m), .sec_tick(sec_tick)
    );

    always #5 hwclk = ~hwclk;

    task automatic step();
        @(posedge hwclk);
        #1;
        if (sec_tick) begin
            tick_cnt++;
            if (mode != 2'd0) bad_ticks++;
        end
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic press(input int which, input int count);
        for (int i = 0; i < count; i++) begin
            if (which == 0) btn_mode = 1'b1; else btn_inc = 1'b1;
            repeat (8) step();
            btn_mode = 1'b0;
            btn_inc  = 1'b0;
            repeat (8) step();
        end
    endtask

    initial begin
        // Reset state
        repeat (2) step();
        check("rst_hhmm", {dh1, dh0, dm1, dm0}, 16'h0000);
        check("rst_mode", mode, 0);
        check("rst_flags", {blank_h, blank_m, sec_tick}, 0);
        rst = 1'b0;
        tick_cnt = 0;

        // Free run: 60 ticks -> 00:01, 3600 ticks -> 01:00
        repeat (241) step();
        check("run_ticks60", tick_cnt, 60);
        check("run_0001", {dh1, dh0, dm1, dm0}, 16'h0001);
        repeat (14401 - 241) step();
        check("run_ticks3600", tick_cnt, 3600);
        check("run_0100", {dh1, dh0, dm1, dm0}, 16'h0100);

        // Rollover to midnight
        rst = 1'b1; step(); rst = 1'b0;
        press(0, 1);
        check("mode_sethours", mode, 1);
        press(1, 23);
        check("set_h23", {dh1, dh0}, 16'h23);
        press(0, 1);
        check("mode_setmin", mode, 2);
        press(1, 59);
        check("set_2359", {dh1, dh0, dm1, dm0}, 16'h2359);
        base = tick_cnt;
        press(0, 1);
        check("mode_run", mode, 0);
        n = 0;
        while (tick_cnt < base + 59 && n < 400) begin step(); n++; end
        step();
        check("pre_roll_ticks", tick_cnt, base + 59);
        check("pre_roll_2359", {dh1, dh0, dm1, dm0}, 16'h2359);
        n = 0;
        while (tick_cnt < base + 60 && n < 20) begin step(); n++; end
        step();
        check("roll_ticks", tick_cnt, base + 60);
        check("roll_0000", {dh1, dh0, dm1, dm0}, 16'h0000);
        check("roll_mode", mode, 0);

        // Wrap without carry
        rst = 1'b1; step(); rst = 1'b0;
        press(0, 1);
        press(1, 25);
        check("hwrap_01", {dh1, dh0, dm1, dm0}, 16'h0100);
        press(0, 1);
        press(1, 59);
        check("min_59", {dh1, dh0, dm1, dm0}, 16'h0159);
        press(1, 1);
        check("mwrap_0100", {dh1, dh0, dm1, dm0}, 16'h0100);

        // Short glitches on inc are filtered
        for (int i = 0; i < 5; i++) begin
            btn_inc = 1'b1; repeat (2) step();
            btn_inc = 1'b0; repeat (4) step();
        end
        check("glitch_nochg", {dh1, dh0, dm1, dm0}, 16'h0100);

        // Mode and inc together in SET_HOURS: mode wins
        press(0, 2);
        check("prio_pre_mode", mode, 1);
        btn_mode = 1'b1; btn_inc = 1'b1;
        repeat (8) step();
        btn_mode = 1'b0; btn_inc = 1'b0;
        repeat (8) step();
        check("prio_mode", mode, 2);
        check("prio_hour", {dh1, dh0}, 16'h01);

        // Blink in SET_MINUTES
        n = 0;
        while (blank_m !== 1'b1 && n < 20) begin step(); n++; end
        check("blink_seen1", blank_m, 1);
        old_dm0 = dm0;
        btn_inc = 1'b1;
        n = 0;
        while (dm0 == old_dm0 && n < 20) begin step(); n++; end
        check("blink_inc_dm0", dm0, 1);
        check("blink_forced0", blank_m, 0);
        check("blink_h0", blank_h, 0);
        repeat (4) step();
        check("blink_c4", blank_m, 0);
        step();
        check("blink_c5", blank_m, 1);
        repeat (4) step();
        check("blink_c9", blank_m, 1);
        check("blink_h0b", blank_h, 0);
        step();
        check("blink_c10", blank_m, 0);
        btn_inc = 1'b0;
        repeat (8) step();
        press(0, 1);
        check("run_mode", mode, 0);
        check("run_blanks", {blank_h, blank_m}, 0);

        // Reset in SET_MINUTES at 14:37
        press(0, 1);
        press(1, 13);
        press(0, 1);
        press(1, 36);
        check("set_1437", {dh1, dh0, dm1, dm0}, 16'h1437);
        check("set_1437_mode", mode, 2);
        rst = 1'b1;
        step();
        check("midrst_hhmm", {dh1, dh0, dm1, dm0}, 16'h0000);
        check("midrst_mode", mode, 0);
        check("midrst_flags", {blank_h, blank_m, sec_tick}, 0);

        // Button held through reset release yields one event
        btn_mode = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        repeat (10) step();
        check("held_mode", mode, 1);
        btn_mode = 1'b0;
        repeat (8) step();
        check("held_once", mode, 1);

        check("no_tick_in_set", bad_ticks, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
